filtro_sensores: RTL and testbench



---
 rtl/bomba_pkg.sv | 9 +
 rtl/antirrebote.sv | 32 +++
 rtl/filtro_sensores.sv | 52 +++++
 tb/tb_filtro_sensores.sv | 128 ++++++++++++
 4 files changed

// File: rtl/bomba_pkg.sv
// bomba_pkg: shared defaults, fault-FSM states and thermometer-code check
package bomba_pkg;
  localparam int N_SENS_DEF = 3;
  localparam int DEB_CYCLES_DEF = 16;
  typedef enum logic {NORMAL, FALLO} estado_t;
  function automatic logic es_termometro(input logic [31:0] vec);
    return (vec & (vec + 32'd1)) == 32'd0;
  endfunction
endpackage

// File: rtl/antirrebote.sv
// antirrebote: 2-flop synchronizer plus debounce counter for one sensor line
module antirrebote
  import bomba_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
  input  logic ck,
  input  logic rst_i,
  input  logic d,
  output logic f
);
  localparam int CW = $clog2(DEB_CYCLES);
  localparam logic [CW-1:0] CMAX = CW'(DEB_CYCLES - 1);
  logic s1, s2;
  logic [CW-1:0] cnt;
  // synchronize, then accept s2 only after DEB_CYCLES consecutive cycles away from f
  always_ff @(posedge ck or posedge rst_i)
    if (rst_i) begin
      s1  <= 1'b0;
      s2  <= 1'b0;
      f   <= 1'b0;
      cnt <= '0;
    end else begin
      s1 <= d;
      s2 <= s1;
      if (s2 == f) cnt <= '0;
      else if (cnt == CMAX) begin
        f   <= s2;
        cnt <= '0;
      end else cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/filtro_sensores.sv
// filtro_sensores: debounced, plausibility-checked tank level bus for bomba1
module filtro_sensores
  import bomba_pkg::*;
#(
  parameter int N_SENS     = N_SENS_DEF,
  parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
  input  logic              ck,
  input  logic              rst_i,
  input  logic [N_SENS-1:0] sensores_i,
  input  logic              limpiar_i,
  output logic [N_SENS-1:0] sensores_o,
  output logic              cambio_o,
  output logic              fallo_o
);
  logic [N_SENS-1:0] f_vec, sens_nxt, sens_prev;
  logic valido;
  estado_t estado, estado_nxt;
  for (genvar i = 0; i < N_SENS; i++) begin : g_deb
    antirrebote #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
      .ck   (ck),
      .rst_i(rst_i),
      .d    (sensores_i[i]),
      .f    (f_vec[i])
    );
  end
  assign valido = es_termometro(32'(f_vec));
  // fault state register
  always_ff @(posedge ck or posedge rst_i)
    if (rst_i) estado <= NORMAL;
    else estado <= estado_nxt;
  // enter fault on a bad pattern; leave only on clear with a good pattern
  always_comb
    estado_nxt = (estado == NORMAL) ? (valido ? NORMAL : FALLO)
                                    : ((limpiar_i && valido) ? NORMAL : FALLO);
  // force "tank full" while faulted, using next state so output and flag move together
  always_comb begin
    sens_nxt = (estado_nxt == FALLO) ? '1 : f_vec;
    fallo_o  = (estado == FALLO);
  end
  // registered output bus and one-cycle change pulse
  always_ff @(posedge ck or posedge rst_i)
    if (rst_i) begin
      sensores_o <= '0;
      sens_prev  <= '0;
      cambio_o   <= 1'b0;
    end else begin
      sensores_o <= sens_nxt;
      sens_prev  <= sensores_o;
      cambio_o   <= (sensores_o != sens_prev);
    end
endmodule

// File: tb/tb_filtro_sensores.sv
// tb_filtro_sensores: directed self-checking bench for filtro_sensores
module tb_filtro_sensores;
  logic ck = 1'b0;
  logic rst_i = 1'b1;
  logic [2:0] sensores_i = '0;
  logic limpiar_i = 1'b0;
  logic [2:0] sensores_o;
  logic cambio_o, fallo_o;
  logic [3:0] sens2_i = '0;
  logic [3:0] sens2_o;
  logic cambio2_o, fallo2_o;
  int checks = 0;
  int errors = 0;
  logic glitch_pulse;

  always #5 ck = ~ck;

  filtro_sensores dut (
    .ck(ck), .rst_i(rst_i), .sensores_i(sensores_i), .limpiar_i(limpiar_i),
    .sensores_o(sensores_o), .cambio_o(cambio_o), .fallo_o(fallo_o)
  );

  filtro_sensores #(.N_SENS(4), .DEB_CYCLES(2)) dut2 (
    .ck(ck), .rst_i(rst_i), .sensores_i(sens2_i), .limpiar_i(1'b0),
    .sensores_o(sens2_o), .cambio_o(cambio2_o), .fallo_o(fallo2_o)
  );

  task automatic tick(input int n);
    repeat (n) @(negedge ck);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    tick(3);
    chk("rst_sens", 32'(sensores_o), 32'h0);
    chk("rst_fallo", 32'(fallo_o), 32'h0);
    chk("rst_cambio", 32'(cambio_o), 32'h0);
    rst_i = 1'b0;
    tick(2);
    sensores_i = 3'b001;
    tick(18);
    chk("rise_k17", 32'(sensores_o), 32'h0);
    tick(1);
    chk("rise_k18", 32'(sensores_o), 32'h1);
    chk("rise_cambio_lo", 32'(cambio_o), 32'h0);
    tick(1);
    chk("rise_cambio_hi", 32'(cambio_o), 32'h1);
    tick(1);
    chk("rise_cambio_end", 32'(cambio_o), 32'h0);
    tick(3);
    sensores_i = 3'b011;
    tick(15);
    sensores_i = 3'b001;
    glitch_pulse = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick(1);
      if (cambio_o) glitch_pulse = 1'b1;
    end
    chk("glitch15_sens", 32'(sensores_o), 32'h1);
    chk("glitch15_cambio", 32'(glitch_pulse), 32'h0);
    sensores_i = 3'b011;
    tick(16);
    sensores_i = 3'b001;
    tick(3);
    chk("glitch16_accept", 32'(sensores_o), 32'h3);
    tick(40);
    chk("glitch16_back", 32'(sensores_o), 32'h1);
    sensores_i = 3'b101;
    tick(18);
    chk("fault_pre", 32'(fallo_o), 32'h0);
    tick(1);
    chk("fault_sens", 32'(sensores_o), 32'h7);
    chk("fault_flag", 32'(fallo_o), 32'h1);
    tick(1);
    chk("fault_cambio", 32'(cambio_o), 32'h1);
    limpiar_i = 1'b1;
    tick(1);
    limpiar_i = 1'b0;
    chk("clr_bad_flag", 32'(fallo_o), 32'h1);
    chk("clr_bad_sens", 32'(sensores_o), 32'h7);
    sensores_i = 3'b011;
    tick(18);
    chk("clr_wait_flag", 32'(fallo_o), 32'h1);
    limpiar_i = 1'b1;
    tick(1);
    limpiar_i = 1'b0;
    chk("clr_ok_sens", 32'(sensores_o), 32'h3);
    chk("clr_ok_flag", 32'(fallo_o), 32'h0);
    chk("clr_ok_cambio_lo", 32'(cambio_o), 32'h0);
    tick(1);
    chk("clr_ok_cambio_hi", 32'(cambio_o), 32'h1);
    tick(3);
    sensores_i = 3'b111;
    tick(12);
    #2 rst_i = 1'b1;
    #1;
    chk("arst_sens", 32'(sensores_o), 32'h0);
    chk("arst_flag", 32'(fallo_o), 32'h0);
    chk("arst_cambio", 32'(cambio_o), 32'h0);
    tick(2);
    rst_i = 1'b0;
    tick(18);
    chk("arst_k17_sens", 32'(sensores_o), 32'h0);
    chk("arst_k17_cambio", 32'(cambio_o), 32'h0);
    tick(1);
    chk("arst_k18_sens", 32'(sensores_o), 32'h7);
    chk("arst_k18_flag", 32'(fallo_o), 32'h0);
    sens2_i = 4'b0111;
    tick(4);
    chk("p2_k3", 32'(sens2_o), 32'h0);
    tick(1);
    chk("p2_0111", 32'(sens2_o), 32'h7);
    chk("p2_0111_flag", 32'(fallo2_o), 32'h0);
    sens2_i = 4'b1011;
    tick(5);
    chk("p2_1011_sens", 32'(sens2_o), 32'hF);
    chk("p2_1011_flag", 32'(fallo2_o), 32'h1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
